// File: rtl/bcd_score_tracker.sv
// Game score tracker: cascaded BCD score counter, high-score register, and a 7-segment display mux.
// Define SCORE_BLANK_EN to blank leading zero digits above the units digit.
module bcd_score_tracker #(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 20
) (
  input  logic                  game_clk,
  input  logic                  rst,
  input  logic [1:0]            game_state,
  input  logic                  mode,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [7*DIGITS-1:0]   display_all,
  output logic                  new_record,
  output logic                  saturated
);

  localparam int TickW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_POINT - 1);

  typedef enum logic [1:0] {
    GsInit  = 2'd0,
    GsStart = 2'd1,
    GsEnd   = 2'd2,
    GsReset = 2'd3
  } gameState_e;

  gameState_e             state;
  logic [4*DIGITS-1:0]    score_q, score_d;
  logic [4*DIGITS-1:0]    high_q, high_d;
  logic [TickW-1:0]       tick_q, tick_d;
  logic                   prevEnd_q, prevEnd_d;
  logic                   newRecord_q, newRecord_d;
  logic [4*DIGITS-1:0]    scoreInc;
  logic                   incCarry;
  logic                   allNines;
  logic [4*DIGITS-1:0]    dispSrc;

  assign state = gameState_e'(game_state);

  function automatic logic [6:0] segOf(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1000000;
    endcase
    return seg;
  endfunction

  // Ripple a +1 through every digit; the carry stops at the first non-nine digit.
  always_comb begin
    scoreInc = score_q;
    incCarry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (incCarry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          scoreInc[4*i +: 4] = 4'd0;
        end else begin
          scoreInc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          incCarry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    allNines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) allNines = 1'b0;
    end
  end

  always_comb begin
    score_d     = score_q;
    high_d      = high_q;
    tick_d      = tick_q;
    newRecord_d = 1'b0;
    prevEnd_d   = (state == GsEnd);
    case (state)
      GsStart: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          if (!allNines) score_d = scoreInc;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      // Only the first END cycle compares; packed BCD orders the same as binary.
      GsEnd: begin
        if (!prevEnd_q && (score_q > high_q)) begin
          high_d      = score_q;
          newRecord_d = 1'b1;
        end
      end
      GsReset: begin
        score_d = '0;
        tick_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      score_q     <= '0;
      high_q      <= '0;
      tick_q      <= '0;
      prevEnd_q   <= 1'b0;
      newRecord_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      high_q      <= high_d;
      tick_q      <= tick_d;
      prevEnd_q   <= prevEnd_d;
      newRecord_q <= newRecord_d;
    end
  end

`ifdef SCORE_BLANK_EN
  logic leadZero;
`endif

  always_comb begin
    dispSrc     = mode ? high_q : score_q;
    display_all = '0;
`ifdef SCORE_BLANK_EN
    leadZero = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      display_all[7*i +: 7] = segOf(dispSrc[4*i +: 4]);
`ifdef SCORE_BLANK_EN
      if (dispSrc[4*i +: 4] != 4'd0) leadZero = 1'b0;
      if (leadZero && (i != 0)) display_all[7*i +: 7] = 7'b1111111;
`endif
    end
  end

  assign score_bcd  = score_q;
  assign high_bcd   = high_q;
  assign new_record = newRecord_q;
  assign saturated  = allNines;

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Self-checking bench for bcd_score_tracker: vector table with scoreboard on the default-rate instance,
// plus counting/carry/saturation sequences on a one-tick-per-point instance.
module tb_bcd_score_tracker;

  logic        game_clk = 1'b0;
  logic        rst;
  logic [1:0]  gameState;
  logic        mode;
  logic [15:0] scoreBcd, highBcd;
  logic [27:0] displayAll;
  logic        newRecord, saturated;

  logic        satRst;
  logic [1:0]  satState;
  logic        satMode;
  logic [15:0] satScore, satHigh;
  logic [27:0] satDisplay;
  logic        satNewRecord, satSaturated;

  int checks = 0;
  int errors = 0;

  always #5 game_clk = ~game_clk;

  bcd_score_tracker #(.DIGITS(4), .TICKS_PER_POINT(20)) dut (
    .game_clk(game_clk), .rst(rst), .game_state(gameState), .mode(mode),
    .score_bcd(scoreBcd), .high_bcd(highBcd), .display_all(displayAll),
    .new_record(newRecord), .saturated(saturated)
  );

  bcd_score_tracker #(.DIGITS(4), .TICKS_PER_POINT(1)) satDut (
    .game_clk(game_clk), .rst(satRst), .game_state(satState), .mode(satMode),
    .score_bcd(satScore), .high_bcd(satHigh), .display_all(satDisplay),
    .new_record(satNewRecord), .saturated(satSaturated)
  );

  typedef struct {
    string       name;
    logic [1:0]  gs;
    logic        md;
    int          cycles;
    logic [15:0] expScore;
    logic [15:0] expHigh;
    logic        expNr;
    logic        expSat;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] score;
    logic [15:0] high;
    logic        nr;
    logic        sat;
    logic [27:0] disp;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];

  function automatic logic [6:0] segModel(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic [27:0] dispModel(input logic [15:0] v);
    logic [27:0] r;
    bit          lead;
    r    = '0;
    lead = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      r[7*i +: 7] = segModel(v[4*i +: 4]);
      if (v[4*i +: 4] != 4'd0) lead = 1'b0;
`ifdef SCORE_BLANK_EN
      if (lead && (i != 0)) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  function automatic logic [15:0] toBcd(input int n);
    logic [15:0] r;
    int          m;
    m = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic vec_t mkVec(input string nm, input logic [1:0] gs, input logic md, input int cyc,
                                 input logic [15:0] sc, input logic [15:0] hi, input logic nr, input logic st);
    vec_t v;
    v.name = nm; v.gs = gs; v.md = md; v.cycles = cyc;
    v.expScore = sc; v.expHigh = hi; v.expNr = nr; v.expSat = st;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    gameState = v.gs;
    mode      = v.md;
    e.name  = v.name;
    e.score = v.expScore;
    e.high  = v.expHigh;
    e.nr    = v.expNr;
    e.sat   = v.expSat;
    e.disp  = dispModel(v.md ? v.expHigh : v.expScore);
    sbQ.push_back(e);
    repeat (v.cycles) @(posedge game_clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbQ.pop_front();
      checkVal({e.name, " score"}, 32'(scoreBcd), 32'(e.score));
      checkVal({e.name, " high"}, 32'(highBcd), 32'(e.high));
      checkVal({e.name, " new_record"}, 32'(newRecord), 32'(e.nr));
      checkVal({e.name, " saturated"}, 32'(saturated), 32'(e.sat));
      checkVal({e.name, " display"}, 32'(displayAll), 32'(e.disp));
    end
  endtask

  task automatic satStep(input int n);
    repeat (n) @(posedge game_clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; gameState = 2'd0; mode = 1'b0;
    satRst = 1'b1; satState = 2'd0; satMode = 1'b0;
    @(posedge game_clk); #1;
    checkVal("reset score", 32'(scoreBcd), 32'h0);
    checkVal("reset high", 32'(highBcd), 32'h0);
    checkVal("reset new_record", 32'(newRecord), 32'h0);
    checkVal("reset saturated", 32'(saturated), 32'h0);
    checkVal("reset display", 32'(displayAll), 32'(dispModel(16'h0000)));
    rst = 1'b0; satRst = 1'b0;

    vecs.push_back(mkVec("start19",    2'd1, 1'b0, 19,  16'h0000, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mkVec("start20",    2'd1, 1'b0, 1,   16'h0001, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mkVec("start200",   2'd1, 1'b0, 180, 16'h0010, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mkVec("end_entry",  2'd2, 1'b0, 1,   16'h0010, 16'h0010, 1'b1, 1'b0));
    vecs.push_back(mkVec("end_hold1",  2'd2, 1'b0, 1,   16'h0010, 16'h0010, 1'b0, 1'b0));
    vecs.push_back(mkVec("end_hold10", 2'd2, 1'b0, 10,  16'h0010, 16'h0010, 1'b0, 1'b0));
    vecs.push_back(mkVec("reset1",     2'd3, 1'b0, 1,   16'h0000, 16'h0010, 1'b0, 1'b0));
    vecs.push_back(mkVec("init_hold",  2'd0, 1'b0, 5,   16'h0000, 16'h0010, 1'b0, 1'b0));
    vecs.push_back(mkVec("start42",    2'd1, 1'b0, 840, 16'h0042, 16'h0010, 1'b0, 1'b0));
    vecs.push_back(mkVec("end42",      2'd2, 1'b0, 1,   16'h0042, 16'h0042, 1'b1, 1'b0));
    vecs.push_back(mkVec("end42_hold", 2'd2, 1'b0, 10,  16'h0042, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("reset2",     2'd3, 1'b0, 1,   16'h0000, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("show_high",  2'd3, 1'b1, 1,   16'h0000, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("init_mode1", 2'd0, 1'b1, 3,   16'h0000, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("start30",    2'd1, 1'b0, 600, 16'h0030, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("end30",      2'd2, 1'b1, 1,   16'h0030, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("restart",    2'd1, 1'b0, 20,  16'h0031, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("end31",      2'd2, 1'b0, 1,   16'h0031, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("start_eq",   2'd1, 1'b0, 220, 16'h0042, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("end_equal",  2'd2, 1'b0, 1,   16'h0042, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("start43",    2'd1, 1'b0, 20,  16'h0043, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec("end43",      2'd2, 1'b0, 1,   16'h0043, 16'h0043, 1'b1, 1'b0));
    vecs.push_back(mkVec("start_part", 2'd1, 1'b0, 10,  16'h0043, 16'h0043, 1'b0, 1'b0));
    vecs.push_back(mkVec("init_mid",   2'd0, 1'b0, 7,   16'h0043, 16'h0043, 1'b0, 1'b0));
    vecs.push_back(mkVec("start_9",    2'd1, 1'b0, 9,   16'h0043, 16'h0043, 1'b0, 1'b0));
    vecs.push_back(mkVec("start_10th", 2'd1, 1'b0, 1,   16'h0044, 16'h0043, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Asynchronous reset in the middle of a START run
    gameState = 2'd1; mode = 1'b0;
    repeat (30) @(posedge game_clk);
    #2;
    checkVal("pre_rst score", 32'(scoreBcd), 32'h0045);
    rst = 1'b1;
    #1;
    checkVal("async_rst score", 32'(scoreBcd), 32'h0);
    checkVal("async_rst high", 32'(highBcd), 32'h0);
    checkVal("async_rst new_record", 32'(newRecord), 32'h0);
    checkVal("async_rst saturated", 32'(saturated), 32'h0);
    checkVal("async_rst display", 32'(displayAll), 32'(dispModel(16'h0000)));
    mode = 1'b1;
    #1;
    checkVal("async_rst display_high", 32'(displayAll), 32'(dispModel(16'h0000)));
    mode = 1'b0;
    @(posedge game_clk); #1;
    rst = 1'b0;

    // Reset held through an END entry must block the high-score update
    gameState = 2'd1;
    repeat (40) @(posedge game_clk);
    #1;
    checkVal("prio score", 32'(scoreBcd), 32'h0002);
    gameState = 2'd2; rst = 1'b1;
    @(posedge game_clk); #1;
    checkVal("prio high", 32'(highBcd), 32'h0);
    checkVal("prio new_record", 32'(newRecord), 32'h0);
    rst = 1'b0; gameState = 2'd0;
    @(posedge game_clk); #1;
    checkVal("prio_after high", 32'(highBcd), 32'h0);
    checkVal("prio_after new_record", 32'(newRecord), 32'h0);

    // One point per cycle on satDut: digit patterns, carry ripple, saturation
    satState = 2'd1;
    for (int k = 1; k <= 20; k++) begin
      satStep(1);
      checkVal($sformatf("count%0d score", k), 32'(satScore), 32'(toBcd(k)));
      checkVal($sformatf("count%0d display", k), 32'(satDisplay), 32'(dispModel(toBcd(k))));
    end
    satStep(979);
    checkVal("carry999 score", 32'(satScore), 32'h0999);
    satStep(1);
    checkVal("carry1000 score", 32'(satScore), 32'h1000);
    checkVal("carry1000 digit3", 32'(satDisplay[27:21]), 32'(7'b1111001));
    checkVal("carry1000 display", 32'(satDisplay), 32'(dispModel(16'h1000)));
    satStep(8998);
    checkVal("sat9998 score", 32'(satScore), 32'h9998);
    checkVal("sat9998 saturated", 32'(satSaturated), 32'h0);
    satStep(1);
    checkVal("sat9999 score", 32'(satScore), 32'h9999);
    checkVal("sat9999 saturated", 32'(satSaturated), 32'h1);
    satStep(40);
    checkVal("sat_hold score", 32'(satScore), 32'h9999);
    checkVal("sat_hold saturated", 32'(satSaturated), 32'h1);
    checkVal("sat_hold display", 32'(satDisplay), 32'(dispModel(16'h9999)));
    satState = 2'd2;
    satStep(1);
    checkVal("sat_end high", 32'(satHigh), 32'h9999);
    checkVal("sat_end new_record", 32'(satNewRecord), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_score_tracker.md
BCD_SCORE_TRACKER -- requirements
Module: bcd_score_tracker

Interface
REQ-001 Parameters SHALL be DIGITS, default 4, number of decimal digits (1..8).
REQ-002 Parameters SHALL include TICKS_PER_POINT, default 20, game_clk cycles in GAME_START per score increment (>=1).
REQ-003 game_clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 game_state  in  2  0=INIT, 1=START, 2=END, 3=RESET.
REQ-006 mode  in  1  0 = display current score, 1 = display high score.
REQ-007 score_bcd  out  4*DIGITS  current score, packed BCD, digit i at [4i+3:4i], digit 0 = units.
REQ-008 high_bcd  out  4*DIGITS  high score, packed BCD, same layout.
REQ-009 display_all  out  7*DIGITS  active-low 7-segment codes, digit i at [7i+6:7i].
REQ-010 new_record  out  1  registered one-cycle pulse on high-score update.
REQ-011 saturated  out  1  high while score equals all nines.

Function
REQ-012 Score SHALL be held as DIGITS cascaded BCD counters; no binary-to-decimal division.
REQ-013 Tick counter SHALL be ceil(log2(TICKS_PER_POINT)) bits wide (minimum 1) and SHALL advance only in START.
REQ-014 In START, when tick == TICKS_PER_POINT-1: tick <= 0 and score increments by 1 on that edge; otherwise tick increments.
REQ-015 Increment carry SHALL ripple through all digits on the same edge: digit 9 wraps to 0 and carries.
REQ-016 At all-nines, score SHALL saturate and not wrap; saturated=1; tick keeps cycling.
REQ-017 INIT: score, tick, high hold.
REQ-018 END: score and tick hold.
REQ-019 On the first edge with game_state==END after a non-END cycle, if score > high (BCD magnitude compare), high <= score and new_record <= 1 for exactly one cycle.
REQ-020 If score <= high on END entry, high SHALL be unchanged and new_record SHALL stay 0.
REQ-021 Remaining in END SHALL NOT re-trigger the END-entry compare.
REQ-022 RESET: score <= 0 and tick <= 0; high SHALL be preserved.
REQ-023 END-entry detection SHALL use a registered previous-state-is-END flag; START->END->START->END SHALL compare on each END entry.
REQ-024 display_all SHALL be combinational from the selected source (mode=0 score, mode=1 high).
REQ-025 Segment codes for 0..9 SHALL be 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-026 Any non-BCD nibble SHALL display 1000000.
REQ-027 Changing mode SHALL affect display_all only; no sequential state changes.

Reset
REQ-028 rst SHALL asynchronously clear score, high, tick, the previous-state flag, and new_record; resulting outputs are score_bcd=0, high_bcd=0, new_record=0, saturated=0, display_all = all digits 1000000 (subject to REQ-030).
REQ-029 rst asserted mid-game SHALL take priority over every game_state action; no high update occurs in the reset cycle.

Configuration
REQ-030 Macro SCORE_BLANK_EN defined: leading zero digits above digit 0 SHALL display 1111111 (blank), while digit 0 always shows its value; macro undefined: all digits always displayed, including leading zeros.

Verification
REQ-031 rst, START for 20 cycles -> score_bcd=0x0001; tick=0; after 200 START cycles -> 0x0010.
REQ-032 Preload to score 0x0999 via START, one more point -> 0x1000 on a single edge; display_all digit3 = 1111001.
REQ-033 Score 0x9999, 40 more START cycles -> score stays 0x9999, saturated=1.
REQ-034 Score 0x0042, high 0x0000, enter END -> next edge high_bcd=0x0042, new_record=1 for 1 cycle; stay in END 10 cycles -> no further pulse; RESET -> score 0, high 0x0042; mode=1 shows 0042.
REQ-035 Second game reaches 0x0030 then END -> high stays 0x0042, new_record=0.
REQ-036 With SCORE_BLANK_EN, score 0x0007 -> digits 3..1 = 1111111, digit0 = 1111000; score 0x0000 -> digit0 = 1000000; rst asserted mid-START -> all outputs at reset values immediately.
